// File: rtl/optic_flow_accum_ci.sv
// Optic-flow custom instruction for the OpenRISC virtual prototype.
// The compute opcode turns two gradient words into 8 per-pixel flow nibbles
// and accumulates the direction totals. The control opcode clears, reads or
// reports the status of those totals.
//
// Handshake: a cycle with start=1 and ciN equal to one of the two opcodes is
// accepted unconditionally. done pulses high for exactly the following cycle,
// and result carries the answer in that cycle. result is 0 whenever done is 0,
// so several blocks can share an OR-ed result bus. There is no busy state, so
// start may assert again in the cycle where done is high.
module optic_flow_accum_ci #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         COUNT_WIDTH         = 16,
    parameter bit         SATURATE            = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    // Control opcode is the next ID; the 8-bit add wraps 255 to 0.
    localparam logic [7:0] CTRL_ID = customInstructionId + 8'd1;

    typedef enum logic [1:0] {
        OP_CLEAR      = 2'd0,
        OP_READ       = 2'd1,
        OP_READ_CLEAR = 2'd2,
        OP_STATUS     = 2'd3
    } ctrl_op_e;

    // Counter order: 0 up, 1 down, 2 left, 3 right, 4 words.
    logic [COUNT_WIDTH-1:0] cnt     [5];
    logic [COUNT_WIDTH-1:0] cnt_nxt [5];
    logic                   done_nxt;
    logic [31:0]            result_nxt;

    logic       compute_hit;
    logic       ctrl_hit;
    ctrl_op_e   op;
    logic [2:0] sel;

    assign compute_hit = start && (ciN == customInstructionId);
    assign ctrl_hit    = start && (ciN == CTRL_ID);
    assign op          = ctrl_op_e'(valueA[1:0]);
    assign sel         = valueB[2:0];

    // Per-pixel gradient bits. Index 8 of the x vectors is the zero pad that
    // the rightmost pixel sees as its neighbour.
    logic [8:0]  ux, pux;
    logic [7:0]  uy, dy, puy, pdy;
    logic [7:0]  up_v, down_v, left_v, right_v;
    logic [31:0] flow;
    logic [15:0] unused_lower_x;
    logic        la, ra, ua, da;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Add 0..8 to a counter, clamping or wrapping on overflow.
    function automatic logic [COUNT_WIDTH-1:0] count_add(
        input logic [COUNT_WIDTH-1:0] a,
        input logic [3:0]             inc
    );
        logic [COUNT_WIDTH:0] s;
        s = {1'b0, a} + {{(COUNT_WIDTH-3){1'b0}}, inc};
        if (SATURATE && s[COUNT_WIDTH]) begin
            return '1;
        end
        return s[COUNT_WIDTH-1:0];
    endfunction

    // Unpack operands and form the 8 flow nibbles.
    always_comb begin
        ux             = '0;
        pux            = '0;
        uy             = '0;
        dy             = '0;
        puy            = '0;
        pdy            = '0;
        up_v           = '0;
        down_v         = '0;
        left_v         = '0;
        right_v        = '0;
        flow           = '0;
        unused_lower_x = '0;
        la             = 1'b0;
        ra             = 1'b0;
        ua             = 1'b0;
        da             = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ux[i]  = valueA[16 + 2*i];
            uy[i]  = valueA[17 + 2*i];
            dy[i]  = valueA[2*i + 1];
            pux[i] = valueB[16 + 2*i];
            puy[i] = valueB[17 + 2*i];
            pdy[i] = valueB[2*i + 1];
            // Lower-row x bits carry no flow information.
            unused_lower_x[i]     = valueA[2*i];
            unused_lower_x[8 + i] = valueB[2*i];
        end
        for (int i = 0; i < 8; i++) begin
            la         = ux[i] & pux[i+1];
            ra         = ux[i+1] & pux[i];
            ua         = uy[i] & pdy[i];
            da         = dy[i] & puy[i];
            up_v[i]    = ua & ~da;
            down_v[i]  = da & ~ua;
            left_v[i]  = la & ~ra;
            right_v[i] = ra & ~la;
            flow[4*i +: 4] = {up_v[i], down_v[i], left_v[i], right_v[i]};
        end
    end

    // Decode the accepted instruction into next counter values and result.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            cnt_nxt[k] = cnt[k];
        end
        done_nxt   = 1'b0;
        result_nxt = '0;
        if (compute_hit) begin
            done_nxt   = 1'b1;
            result_nxt = flow;
            cnt_nxt[0] = count_add(cnt[0], popcount8(up_v));
            cnt_nxt[1] = count_add(cnt[1], popcount8(down_v));
            cnt_nxt[2] = count_add(cnt[2], popcount8(left_v));
            cnt_nxt[3] = count_add(cnt[3], popcount8(right_v));
            cnt_nxt[4] = count_add(cnt[4], 4'd1);
        end else if (ctrl_hit) begin
            done_nxt = 1'b1;
            case (op)
                OP_CLEAR: begin
                    for (int k = 0; k < 5; k++) begin
                        cnt_nxt[k] = '0;
                    end
                end
                OP_READ, OP_READ_CLEAR: begin
                    // Selects 5..7 match no counter: read 0, clear nothing.
                    for (int k = 0; k < 5; k++) begin
                        if (sel == 3'(k)) begin
                            result_nxt = 32'(cnt[k]);
                            if (op == OP_READ_CLEAR) begin
                                cnt_nxt[k] = '0;
                            end
                        end
                    end
                end
                OP_STATUS: begin
                    for (int k = 0; k < 5; k++) begin
                        result_nxt[k] = &cnt[k];
                    end
                end
                default: result_nxt = '0;
            endcase
        end
    end

    // Register outputs and counters; reset wins over any start.
    always_ff @(posedge clock) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
            for (int k = 0; k < 5; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            done   <= done_nxt;
            result <= result_nxt;
            for (int k = 0; k < 5; k++) begin
                cnt[k] <= cnt_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_optic_flow_accum_ci.sv
// Directed bench for optic_flow_accum_ci. Four instances share the operand
// bus and each has its own start: default (ID 0, 16-bit, saturating),
// 4-bit saturating, 4-bit wrapping, and ID 255 (control opcode wraps to 0).
module tb_optic_flow_accum_ci;

    localparam int M_MAIN = 0;
    localparam int M_SAT4 = 1;
    localparam int M_WRP4 = 2;
    localparam int M_HI   = 3;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0]  ciN    = 8'd0;
    logic [31:0] valueA = '0;
    logic [31:0] valueB = '0;
    logic [3:0]  start_v = '0;

    logic        done_main, done_sat4, done_wrp4, done_hi;
    logic [31:0] result_main, result_sat4, result_wrp4, result_hi;

    optic_flow_accum_ci #(.customInstructionId(8'd0), .COUNT_WIDTH(16), .SATURATE(1'b1)) u_main (
        .clock(clock), .reset(reset), .start(start_v[M_MAIN]), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done_main), .result(result_main));
    optic_flow_accum_ci #(.customInstructionId(8'd0), .COUNT_WIDTH(4), .SATURATE(1'b1)) u_sat4 (
        .clock(clock), .reset(reset), .start(start_v[M_SAT4]), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done_sat4), .result(result_sat4));
    optic_flow_accum_ci #(.customInstructionId(8'd0), .COUNT_WIDTH(4), .SATURATE(1'b0)) u_wrp4 (
        .clock(clock), .reset(reset), .start(start_v[M_WRP4]), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done_wrp4), .result(result_wrp4));
    optic_flow_accum_ci #(.customInstructionId(8'd255), .COUNT_WIDTH(16), .SATURATE(1'b1)) u_hi (
        .clock(clock), .reset(reset), .start(start_v[M_HI]), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done_hi), .result(result_hi));

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int          inst_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got done=%b result=%h, expected done=%b result=%h",
                     tag, got[32], got[31:0], exp[32], exp[31:0]);
        end
    endtask

    function automatic logic [32:0] observe(input int inst);
        case (inst)
            M_MAIN:  return {done_main, result_main};
            M_SAT4:  return {done_sat4, result_sat4};
            M_WRP4:  return {done_wrp4, result_wrp4};
            default: return {done_hi, result_hi};
        endcase
    endfunction

    // Compare the oldest expectation; called at a falling edge, after the
    // rising edge that registered the corresponding instruction.
    task automatic compare_pending();
        logic [32:0] e;
        int          inst;
        string       tag;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            inst = inst_q.pop_front();
            tag  = tag_q.pop_front();
            check(tag, observe(inst), e);
        end
    endtask

    // ---------------- driver ----------------
    // One cycle: check the previous cycle's outcome, then drive this one and
    // queue what the watched instance must show one cycle later.
    task automatic step(input logic rst, input logic [3:0] mask, input logic [7:0] ci,
                        input logic [31:0] a, input logic [31:0] b, input int inst,
                        input logic exp_done, input logic [31:0] exp_result, input string tag);
        @(negedge clock);
        compare_pending();
        reset   = rst;
        start_v = mask;
        ciN     = ci;
        valueA  = a;
        valueB  = b;
        exp_q.push_back({exp_done, exp_result});
        inst_q.push_back(inst);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input int inst, input string tag);
        step(1'b0, 4'b0000, 8'd0, 32'h0, 32'h0, inst, 1'b0, 32'h0, tag);
    endtask

    // Shorthand for the main instance: compute ci=0, control ci=1.
    task automatic mcomp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input string tag);
        step(1'b0, 4'b0001, 8'd0, a, b, M_MAIN, 1'b1, r, tag);
    endtask

    task automatic mctrl(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input string tag);
        step(1'b0, 4'b0001, 8'd1, a, b, M_MAIN, 1'b1, r, tag);
    endtask

    task automatic ctrl_on(input int inst, input logic [7:0] ci, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r, input string tag);
        step(1'b0, 4'(1 << inst), ci, a, b, inst, 1'b1, r, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        step(1'b1, 4'b0000, 8'd0, 32'h0, 32'h0, M_MAIN, 1'b0, 32'h0, "rst_main");
        step(1'b1, 4'b0000, 8'd0, 32'h0, 32'h0, M_HI,   1'b0, 32'h0, "rst_hi");
        idle(M_MAIN, "idle_after_rst");
        mctrl(32'h1, 32'h4, 32'h0, "rst_words_zero");

        // Left at pixel 0, then read back
        mcomp(32'h0001_0000, 32'h0004_0000, 32'h0000_0002, "comp_left_px0");
        mctrl(32'h1, 32'h2, 32'd1, "read_left_1");
        mctrl(32'h1, 32'h4, 32'd1, "read_words_1");

        // All-up, then back-to-back read, then result drops to 0
        mcomp(32'hAAAA_0000, 32'h0000_AAAA, 32'h8888_8888, "comp_all_up");
        mctrl(32'h1, 32'h0, 32'd8, "read_up_b2b");
        idle(M_MAIN, "idle_result_zero");

        // Up and down cancel: no flow, only the word count moves
        mcomp(32'h0002_0002, 32'h0002_0002, 32'h0, "comp_cancel");
        mctrl(32'h1, 32'h0, 32'd8, "read_up_8");
        mctrl(32'h1, 32'h1, 32'd0, "read_down_0");
        mctrl(32'h1, 32'h2, 32'd1, "read_left_still_1");
        mctrl(32'h1, 32'h3, 32'd0, "read_right_0");
        mctrl(32'h1, 32'h4, 32'd3, "read_words_3");

        // Ignored operand bits, out-of-range selects
        mctrl(32'hFFFF_FFFF, 32'h1234_5678, 32'h0, "status_none");
        mctrl(32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0, "read_sel5");
        mctrl(32'h2, 32'h6, 32'h0, "readclr_sel6");
        mctrl(32'h1, 32'h4, 32'd3, "words_after_sel6");
        mctrl(32'h1, 32'h0, 32'd8, "up_after_sel6");

        // Non-matching opcode (ID+2)
        step(1'b0, 4'b0001, 8'd2, 32'hAAAA_0000, 32'h0000_AAAA, M_MAIN, 1'b0, 32'h0, "nohit_ci2");
        mctrl(32'h1, 32'h0, 32'd8, "up_after_nohit");
        mctrl(32'h1, 32'h4, 32'd3, "words_after_nohit");

        // READ_CLEAR only clears the selected counter
        mctrl(32'h2, 32'h2, 32'd1, "readclr_left");
        mctrl(32'h1, 32'h2, 32'd0, "left_cleared");
        mctrl(32'h1, 32'h0, 32'd8, "up_kept");

        // CLEAR
        mctrl(32'h0, 32'h0, 32'h0, "clear");
        mctrl(32'h1, 32'h0, 32'd0, "up_after_clear");
        mctrl(32'h1, 32'h4, 32'd0, "words_after_clear");

        // Down, right, and the pixel-7 edge
        mcomp(32'h0000_AAAA, 32'hAAAA_0000, 32'h4444_4444, "comp_all_down");
        mcomp(32'h0004_0000, 32'h0001_0000, 32'h0000_0001, "comp_right_px0");
        mcomp(32'h4000_0000, 32'h1000_0000, 32'h0100_0000, "comp_right_px6");
        mcomp(32'h4000_0000, 32'h4000_0000, 32'h0000_0000, "comp_px7_edge");
        mctrl(32'h1, 32'h1, 32'd8, "read_down_8");
        mctrl(32'h1, 32'h3, 32'd2, "read_right_2");
        mctrl(32'h1, 32'h2, 32'd0, "read_left_0");
        mctrl(32'h1, 32'h0, 32'd0, "read_up_0");
        mctrl(32'h1, 32'h4, 32'd4, "read_words_4");

        // Start coincident with reset is lost; reset clears counters
        mcomp(32'hAAAA_0000, 32'h0000_AAAA, 32'h8888_8888, "comp_before_rst");
        step(1'b1, 4'b0001, 8'd0, 32'hAAAA_0000, 32'h0000_AAAA, M_MAIN, 1'b0, 32'h0, "start_in_rst");
        mctrl(32'h1, 32'h0, 32'd0, "up_after_rst");
        mctrl(32'h1, 32'h1, 32'd0, "down_after_rst");
        mctrl(32'h1, 32'h3, 32'd0, "right_after_rst");
        mctrl(32'h1, 32'h4, 32'd0, "words_after_rst");

        // 4-bit saturating counters
        ctrl_on(M_SAT4, 8'd0, 32'hAAAA_0000, 32'h0000_AAAA, 32'h8888_8888, "s4_comp1");
        ctrl_on(M_SAT4, 8'd0, 32'hAAAA_0000, 32'h0000_AAAA, 32'h8888_8888, "s4_comp2");
        ctrl_on(M_SAT4, 8'd1, 32'h1, 32'h0, 32'd15, "s4_read_up_15");
        ctrl_on(M_SAT4, 8'd1, 32'h3, 32'h0, 32'h1,  "s4_status");
        ctrl_on(M_SAT4, 8'd1, 32'h2, 32'h0, 32'd15, "s4_readclr_up");
        ctrl_on(M_SAT4, 8'd1, 32'h1, 32'h0, 32'd0,  "s4_up_cleared");
        ctrl_on(M_SAT4, 8'd1, 32'h3, 32'h0, 32'h0,  "s4_status_clr");

        // 4-bit wrapping counters
        ctrl_on(M_WRP4, 8'd0, 32'hAAAA_0000, 32'h0000_AAAA, 32'h8888_8888, "w4_comp1");
        ctrl_on(M_WRP4, 8'd0, 32'hAAAA_0000, 32'h0000_AAAA, 32'h8888_8888, "w4_comp2");
        ctrl_on(M_WRP4, 8'd1, 32'h1, 32'h0, 32'd0, "w4_read_up_wrap");
        ctrl_on(M_WRP4, 8'd1, 32'h1, 32'h4, 32'd2, "w4_read_words");
        ctrl_on(M_WRP4, 8'd1, 32'h3, 32'h0, 32'h0, "w4_status");

        // ID 255: compute on 255, control on 0, 1 is not decoded
        ctrl_on(M_HI, 8'd255, 32'h0001_0000, 32'h0004_0000, 32'h2, "hi_comp");
        ctrl_on(M_HI, 8'd0, 32'h1, 32'h2, 32'd1, "hi_read_left");
        step(1'b0, 4'b1000, 8'd1, 32'h0, 32'h0, M_HI, 1'b0, 32'h0, "hi_nohit_ci1");
        ctrl_on(M_HI, 8'd0, 32'h1, 32'h4, 32'd1, "hi_words_kept");
        ctrl_on(M_HI, 8'd0, 32'h0, 32'h0, 32'h0, "hi_clear");
        ctrl_on(M_HI, 8'd0, 32'h1, 32'h2, 32'd0, "hi_left_cleared");
        ctrl_on(M_HI, 8'd0, 32'h1, 32'h4, 32'd0, "hi_words_cleared");
        idle(M_HI, "hi_idle");

        // Drain the last expectation
        @(negedge clock);
        compare_pending();

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/optic_flow_accum_ci.md
Name: optic_flow_accum_ci

Overview:
Custom-instruction block for the OpenRISC virtual prototype. It computes per-pixel binary optic-flow bits for 8 pixels per call from the current-frame and previous-frame gradient words. It also keeps saturating histogram counters (up/down/left/right, plus a word count) across calls, so software reads flow totals instead of popcounting in C. It uses two consecutive custom-instruction IDs: ID is compute, ID+1 is control.

Parameters:
customInstructionId, 8'd0, compute opcode; control opcode is customInstructionId+1 (mod 256)
COUNT_WIDTH, 16, width of each counter, legal range 4..32
SATURATE, 1, 1 = counters clamp at all-ones; 0 = counters wrap modulo 2^COUNT_WIDTH

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle instruction start pulse from CPU
ciN  input  8  custom-instruction number
valueA  input  32  operand A
valueB  input  32  operand B
done  output  1  one-cycle completion pulse
result  output  32  result, 0 whenever done=0 (OR-bus safe)

Behaviour:
- Reset (sync, highest priority): done=0, result=0, all 5 counters=0, pending state cleared. Any start in the reset cycle is lost.
- Match: compute_hit = start & (ciN==ID); ctrl_hit = start & (ciN==ID+1). No hit means no state change.
- Latency: fixed 1 cycle. Hit at edge t gives done=1 and result valid for exactly cycle t+1, then done=0 and result=0. Both are registered outputs.
- Compute operand packing:
  - valueA[31:16] = current upper row, valueA[15:0] = current lower row; valueB has the same layout for the previous frame.
  - Pixel i: x = bit 2i, y = bit 2i+1 of each half.
  - ux = cur-upper x, pux = prev-upper x, uy = cur-upper y, dy = cur-lower y, puy = prev-upper y, pdy = prev-lower y.
- Compute flow, per pixel i in 0..7:
  - la = ux[i] & pux[i+1]; ra = ux[i+1] & pux[i]. Index 8 reads as 0.
  - left = la & ~ra; right = ra & ~la.
  - ua = uy[i] & pdy[i]; da = dy[i] & puy[i].
  - up = ua & ~da; down = da & ~ua.
  - Result nibble i = {up, down, left, right}, occupying bits 4i+3..4i.
- Compute accumulate, on the same edge that registers the result:
  - cnt_up, cnt_down, cnt_left, cnt_right each add popcount(0..8, zero-extended) of their direction.
  - cnt_words adds 1.
  - SATURATE=1: a sum overflowing COUNT_WIDTH clamps to 2^COUNT_WIDTH-1. SATURATE=0: sum wraps.
  - Counters are visible to any instruction starting on or after cycle t+1.
- Control ops, selected by valueA[1:0]:
  - 0 CLEAR: all counters set to 0; result 0.
  - 1 READ: result = counter selected by valueB[2:0] (0 up, 1 down, 2 left, 3 right, 4 words), zero-extended to 32.
  - 2 READ_CLEAR: result = pre-clear value of the selected counter; only that counter is cleared.
  - 3 STATUS: result[4:0] = per-counter saturated flag (bit k set iff counter k is all-ones); other bits 0.
  - valueB[2:0] in 5..7 reads 0, and READ_CLEAR with that select clears nothing.
  - valueA[31:2] and valueB[31:3] are ignored.
- Back-to-back: start may assert in the cycle done is high. That instruction is accepted and completes the next cycle, so one op per cycle sustained. No busy state and no stall.
- ID+1 wrap: customInstructionId=255 gives control ID 0.

Test Plan:
- Reset, then compute valueA=0x0001_0000, valueB=0x0004_0000 -> done pulses 1 cycle later, result=0x0000_0002 (left, pixel 0). READ sel 2 -> 1; READ sel 4 -> 1.
- Compute valueA=0xAAAA_0000, valueB=0x0000_AAAA -> result=0x8888_8888. Next cycle READ sel 0 -> 8, with no idle cycle between the two ops.
- Compute valueA=0x0002_0002, valueB=0x0002_0002 (ua=da=1 at pixel 0) -> result=0, counters unchanged, cnt_words +1.
- COUNT_WIDTH=4, SATURATE=1: two computes of the all-up pattern -> READ sel 0 = 15, STATUS = 0x1. READ_CLEAR sel 0 returns 15, then READ returns 0. With SATURATE=0 the same sequence reads 0.
- Non-matching ciN=ID+2 with start -> done stays 0, result 0, counters unchanged. Reset asserted the cycle after a compute start -> done 0, all READs return 0.
- customInstructionId=255: ciN=0, valueA=0 (CLEAR) -> done, all counters 0.
